// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter: round-robin arbiter that applies one masked JK command per
// clock to a shared bank of W JK flip-flops (each realised as a T flip-flop fed
// by JK-to-T conversion). Each accepted command gets a one-cycle grant pulse.
module jk_bank_arbiter #(
    parameter int N   = 4,
    parameter int W   = 8,
    localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [2*N-1:0]   cmd,
    input  logic [N*W-1:0]   mask,
    output logic [N-1:0]     gnt,
    output logic [W-1:0]     q,
    output logic [IDW-1:0]   last_id
);

    logic [IDW-1:0] ptr;
    logic [N-1:0]   elig;
    logic           win_vld;
    logic [IDW-1:0] win_id;
    logic [1:0]     win_cmd;
    logic [W-1:0]   win_mask;
    logic [W-1:0]   t_vec;
    logic [W-1:0]   q_nxt;

    // A requester granted last edge sits out this edge so a held req is not re-served.
    assign elig = req & ~gnt;

    // Search for the first eligible requester starting at ptr, wrapping modulo N.
    always_comb begin
        int j;
        win_vld = 1'b0;
        win_id  = '0;
        j       = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!win_vld && elig[j]) begin
                win_vld = 1'b1;
                win_id  = IDW'(j);
            end
        end
    end

    // JK-to-T conversion on the winner's masked bits; unmasked bits keep their state.
    always_comb begin
        win_cmd  = cmd[2*int'(win_id) +: 2];
        win_mask = mask[W*int'(win_id) +: W];
        t_vec    = ({W{win_cmd[1]}} & ~q) | ({W{win_cmd[0]}} & q);
        q_nxt    = q ^ (t_vec & win_mask);
    end

    // Commit the winning command, pulse its grant and advance the pointer past it.
    always_ff @(posedge clk) begin
        if (rst) begin
            q       <= '0;
            gnt     <= '0;
            last_id <= '0;
            ptr     <= '0;
        end else if (win_vld) begin
            q       <= q_nxt;
            gnt     <= {{(N-1){1'b0}}, 1'b1} << win_id;
            last_id <= win_id;
            if (int'(win_id) == N - 1) ptr <= '0;
            else                       ptr <= win_id + IDW'(1);
        end else begin
            gnt <= '0;
        end
    end

endmodule
